// File: rtl/pulse_drive_gen.sv
// Trapezoidal-envelope I/Q drive generator: rise, flat top, fall of a latched complex amplitude.
// Latency: drive/drive_iq one clk after iq is sampled. No backpressure: the stream runs every clk.
module pulse_drive_gen #(
    parameter int dw = 18,
    parameter int cw = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iq,
    input  logic                 trigger,
    input  logic                 abort,
    input  logic signed [dw-1:0] amp_i,
    input  logic signed [dw-1:0] amp_q,
    input  logic        [cw-1:0] ramp_step,
    input  logic        [cw-1:0] flat_len,
    output logic signed [dw-1:0] drive,
    output logic                 drive_iq,
    output logic                 busy,
    output logic                 done,
    output logic        [1:0]    state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RISE = 2'd1,
        S_FLAT = 2'd2,
        S_FALL = 2'd3
    } state_t;

    localparam logic [cw:0] ENV_MAX = {1'b0, {cw{1'b1}}};

    state_t                st;
    logic        [cw:0]    env;
    logic        [cw-1:0]  cnt;
    logic        [cw-1:0]  sh_step;
    logic        [cw-1:0]  sh_flat;
    logic signed [dw-1:0]  sh_amp_i;
    logic signed [dw-1:0]  sh_amp_q;

    logic signed [2*dw-1:0] amp_w;
    logic signed [2*dw-1:0] env_w;
    logic signed [2*dw-1:0] prod;
    logic        [cw+1:0]   rise_sum;
    logic                   rise_top;
    logic                   fall_end;
    logic                   unused_prod;

    // env is zero-extended so the multiply stays signed without a sign flip at ENV_MAX.
    assign amp_w    = (2*dw)'(iq ? sh_amp_q : sh_amp_i);
    assign env_w    = (2*dw)'(env);
    assign prod     = amp_w * env_w;
    assign rise_sum = {1'b0, env} + {2'b00, sh_step};
    assign rise_top = (sh_step == '0) || (rise_sum >= {1'b0, ENV_MAX});
    assign fall_end = (sh_step == '0) || (env <= {1'b0, sh_step});
    assign state    = st;
    assign unused_prod = ^{prod[2*dw-1:dw+cw], prod[cw-1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st       <= S_IDLE;
            env      <= '0;
            cnt      <= '0;
            sh_step  <= '0;
            sh_flat  <= '0;
            sh_amp_i <= '0;
            sh_amp_q <= '0;
            drive    <= '0;
            drive_iq <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // Output uses env from before this edge's update, so I and Q of a pair match.
            drive    <= prod[dw+cw-1:cw];
            drive_iq <= iq;
            done     <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (trigger) begin
                        sh_amp_i <= amp_i;
                        sh_amp_q <= amp_q;
                        sh_step  <= ramp_step;
                        sh_flat  <= flat_len;
                        st       <= S_RISE;
                        busy     <= 1'b1;
                    end
                end
                S_RISE: begin
                    if (abort) begin
                        st <= S_FALL;
                    end else if (iq) begin
                        if (rise_top) begin
                            env <= ENV_MAX;
                            cnt <= sh_flat;
                            st  <= S_FLAT;
                        end else begin
                            env <= rise_sum[cw:0];
                        end
                    end
                end
                S_FLAT: begin
                    if (abort) begin
                        st <= S_FALL;
                    end else if (iq) begin
                        if (cnt == '0) st <= S_FALL;
                        else           cnt <= cnt - cw'(1);
                    end
                end
                S_FALL: begin
                    if (iq) begin
                        if (fall_end) begin
                            env  <= '0;
                            st   <= S_IDLE;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            env <= env - {1'b0, sh_step};
                        end
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_drive_gen.sv
// Bench for pulse_drive_gen: directed scenarios then randomized pulses against a schedule-based model.
module tb_pulse_drive_gen;
    localparam int DW      = 18;
    localparam int CW      = 16;
    localparam int ENV_MAX = 65535;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 iq = 1'b0;
    logic                 trigger = 1'b0;
    logic                 abort = 1'b0;
    logic signed [DW-1:0] amp_i = '0;
    logic signed [DW-1:0] amp_q = '0;
    logic        [CW-1:0] ramp_step = '0;
    logic        [CW-1:0] flat_len = '0;
    logic signed [DW-1:0] drive;
    logic                 drive_iq;
    logic                 busy;
    logic                 done;
    logic        [1:0]    state;

    pulse_drive_gen #(.dw(DW), .cw(CW)) dut (
        .clk(clk), .rst_n(rst_n), .iq(iq), .trigger(trigger), .abort(abort),
        .amp_i(amp_i), .amp_q(amp_q), .ramp_step(ramp_step), .flat_len(flat_len),
        .drive(drive), .drive_iq(drive_iq), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;
    int fails  = 0;

    // Model: env per pair tick comes from a precomputed schedule of (env, state) pairs.
    int   m_env = 0, m_state = 0;
    int   m_sh_i = 0, m_sh_q = 0, m_step = 0, m_flat = 0;
    int   q_env[$];
    int   q_st[$];
    int   e_drive = 0;
    logic e_iq = 1'b0, e_done = 1'b0;

    bit   iq_rand = 1'b0;
    int   obs_max = 0, obs_min = 0, done_cnt = 0;
    bit   saw_flat = 1'b0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_fall(input int from);
        int e = from;
        do begin
            e = (m_step == 0) ? 0 : ((e > m_step) ? e - m_step : 0);
            q_env.push_back(e);
            q_st.push_back(e == 0 ? 0 : 3);
        end while (e != 0);
    endtask

    task automatic build_sched();
        int e = 0;
        q_env.delete();
        q_st.delete();
        do begin
            e = (m_step == 0) ? ENV_MAX : ((e + m_step > ENV_MAX) ? ENV_MAX : e + m_step);
            q_env.push_back(e);
            q_st.push_back(e == ENV_MAX ? 2 : 1);
        end while (e != ENV_MAX);
        for (int k = 0; k < m_flat; k++) begin
            q_env.push_back(ENV_MAX);
            q_st.push_back(2);
        end
        q_env.push_back(ENV_MAX);
        q_st.push_back(3);
        push_fall(ENV_MAX);
    endtask

    task automatic model_edge();
        longint p;
        p       = longint'(iq ? m_sh_q : m_sh_i) * longint'(m_env);
        e_drive = int'(p >>> 16);
        e_iq    = iq;
        e_done  = 1'b0;
        if (!rst_n) begin
            m_env = 0; m_state = 0;
            m_sh_i = 0; m_sh_q = 0; m_step = 0; m_flat = 0;
            q_env.delete(); q_st.delete();
            e_drive = 0; e_iq = 1'b0;
        end else if (m_state == 0) begin
            if (trigger) begin
                m_sh_i = int'(amp_i); m_sh_q = int'(amp_q);
                m_step = int'(ramp_step); m_flat = int'(flat_len);
                build_sched();
                m_state = 1;
            end
        end else if (abort && (m_state == 1 || m_state == 2)) begin
            m_state = 3;
            q_env.delete(); q_st.delete();
            push_fall(m_env);
        end else if (iq) begin
            m_env   = q_env.pop_front();
            m_state = q_st.pop_front();
            if (m_state == 0) e_done = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("drive", $signed(drive), e_drive);
        chk("drive_iq", drive_iq, e_iq);
        chk("busy", busy, m_state != 0);
        chk("done", done, e_done);
        chk("state", state, m_state);
        if ($signed(drive) > obs_max) obs_max = $signed(drive);
        if ($signed(drive) < obs_min) obs_min = $signed(drive);
        if (state == 2'd2) saw_flat = 1'b1;
        if (done) done_cnt++;
        trigger = 1'b0;
        abort   = 1'b0;
        iq = iq_rand ? 1'($urandom_range(0, 1)) : ~iq;
    endtask

    task automatic clr_obs();
        obs_max = 0; obs_min = 0; done_cnt = 0; saw_flat = 1'b0;
    endtask

    task automatic run_until_idle(input int max, input bit rnd);
        int n = 0;
        while (busy && n < max) begin
            if (rnd) begin
                abort = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 29) == 0) begin
                    trigger = 1'b1;
                    amp_i = DW'(int'($urandom_range(0, 262143)) - 131072);
                end
            end
            tick();
            n++;
        end
        chk("idle_bound", busy, 1'b0);
    endtask

    task automatic run_until_state(input int st, input int max);
        int n = 0;
        while (m_state != st && n < max) begin
            tick();
            n++;
        end
        chk("state_bound", state, st);
    endtask

    task automatic start(input int ai, input int aq, input int stp, input int fl);
        amp_i = DW'(ai); amp_q = DW'(aq);
        ramp_step = CW'(stp); flat_len = CW'(fl);
        trigger = 1'b1;
        tick();
    endtask

    initial begin
        // Reset held for 4 clocks
        repeat (4) tick();
        chk("rst_drive", $signed(drive), 0);
        chk("rst_state", state, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Basic trapezoid
        clr_obs();
        start(30000, 0, 16384, 3);
        run_until_idle(400, 1'b0);
        chk("basic_peak_i", obs_max, 29999);
        chk("basic_done_cnt", done_cnt, 1);
        repeat (2) tick();

        // Step mode
        clr_obs();
        start(0, -131072, 0, 0);
        run_until_idle(100, 1'b0);
        chk("step_peak_q", obs_min, -131070);
        chk("step_done_cnt", done_cnt, 1);
        tick();

        // Abort mid-rise at env=20000
        clr_obs();
        start(30000, 10000, 1000, 5);
        for (int n = 0; n < 200 && m_env != 20000; n++) tick();
        while (iq) tick();
        abort = 1'b1;
        tick();
        run_until_idle(400, 1'b0);
        chk("abort_peak_i", obs_max, 9155);
        chk("abort_no_flat", saw_flat, 1'b0);
        chk("abort_done_cnt", done_cnt, 1);
        tick();

        // Retrigger during FLAT is ignored
        clr_obs();
        start(30000, 0, 16384, 10);
        run_until_state(2, 100);
        amp_i = DW'(5000);
        trigger = 1'b1;
        tick();
        run_until_idle(400, 1'b0);
        chk("retrig_peak_i", obs_max, 29999);
        clr_obs();
        start(5000, 0, 16384, 2);
        run_until_idle(400, 1'b0);
        chk("new_peak_i", obs_max, 4999);

        // Reset mid-FLAT
        start(30000, 20000, 16384, 10);
        run_until_state(2, 100);
        clr_obs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_drive", $signed(drive), 0);
        repeat (10) tick();
        chk("midrst_done_cnt", done_cnt, 0);
        chk("midrst_busy", busy, 1'b0);

        // Randomized pulses with aborts, retriggers and irregular iq
        for (int p = 0; p < 25; p++) begin
            iq_rand = ($urandom_range(0, 3) == 0);
            start(int'($urandom_range(0, 262143)) - 131072,
                  int'($urandom_range(0, 262143)) - 131072,
                  ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1500, 40000)),
                  int'($urandom_range(0, 6)));
            run_until_idle(2000, 1'b1);
            repeat (int'($urandom_range(0, 3))) tick();
        end
        iq_rand = 1'b0;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
